universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised successor to the 1-bit serial-in/serial-out shift register.
//  WIDTH-bit register with hold, left/right shift, rotate, parallel load and clear.
//  A shift-count tracker pulses word_valid each time WIDTH serial bits have been taken in.
//  Serves as the serialiser/deserialiser stage for byte-wide datapaths in the behavioural library.
// PARAMETERS
//  WIDTH      8  register width in bits; minimum 2
//  RESET_VAL  0  WIDTH-bit value loaded into the register on reset
// PORTS
//  clock       in   1                 rising-edge clock
//  reset       in   1                 synchronous, active-low reset; sampled on clock rising edge
//  en          in   1                 clock enable; 0 = full hold
//  mode        in   3                 operation select (see BEHAVIOUR)
//  d           in   1                 serial data in
//  pdata       in   WIDTH             parallel load data
//  q           out  1                 serial data out
//  pq          out  WIDTH             register contents (parallel out)
//  bit_cnt     out  $clog2(WIDTH+1)   serial bits shifted in since last load/clear/word
//  word_valid  out  1                 one-cycle pulse: WIDTH serial bits completed
// BEHAVIOUR
//  Reset (reset==0 at an edge) has priority over everything, including en. It sets:
//   - pq=RESET_VAL, bit_cnt=0, word_valid=0
//   - last_dir=RIGHT, so q=RESET_VAL[0]
//  en==0: pq, bit_cnt and last_dir hold; word_valid goes to 0. mode is ignored.
//  en==1, by mode (all registered, single-cycle):
//   000 HOLD  pq unchanged
//   001 SHR   pq<={d,pq[W-1:1]}; last_dir<=RIGHT
//   010 SHL   pq<={pq[W-2:0],d}; last_dir<=LEFT
//   011 ROR   pq<={pq[0],pq[W-1:1]}; last_dir<=RIGHT
//   100 ROL   pq<={pq[W-2:0],pq[W-1]}; last_dir<=LEFT
//   101 LOAD  pq<=pdata
//   110 CLEAR pq<=0
//   111 reserved; behaves exactly as HOLD
//  q is combinational from registers only: q = (last_dir==RIGHT) ? pq[0] : pq[W-1].
//   - No path from d to q in the same cycle.
//   - A bit on d reaches q after WIDTH enabled shifts in the same direction.
//  Counter rules:
//   - bit_cnt increments only on enabled SHR/SHL.
//   - On a shift with bit_cnt==WIDTH-1: bit_cnt<=0 and word_valid<=1 at the same edge.
//     pq holds the complete word while word_valid is high.
//   - word_valid is 0 on every other edge; it never stays high two consecutive cycles
//     unless a new word completes.
//   - LOAD and CLEAR force bit_cnt<=0, word_valid<=0.
//   - HOLD, ROR, ROL and 111 leave bit_cnt unchanged; word_valid<=0.
//   - A direction change mid-word (SHR to SHL) does not reset bit_cnt.
//  Back-to-back words: continuous shifting gives one word_valid pulse every WIDTH cycles,
//   with no gap cycle.
//  Reset mid-word discards the partial word; no word_valid is produced.
// TESTING (WIDTH=8, RESET_VAL=0)
//  1. reset=0 for 2 edges with en=1, mode=LOAD, pdata=8'hFF
//     -> pq=8'h00, q=0, bit_cnt=0, word_valid=0.
//  2. SHR 8 cycles, d=1,0,1,1,0,0,1,0 (in order)
//     -> pq=8'h4D after the 8th edge; word_valid=1 for exactly that cycle; bit_cnt=0.
//  3. LOAD 8'hA5, then SHR 8 cycles with d=0
//     -> q before each shift = 1,0,1,0,0,1,0,1; final pq=8'h00; word_valid pulses once.
//  4. LOAD 8'h81; ROL -> 8'h03; ROR twice -> 8'hC0
//     -> bit_cnt=0 throughout, word_valid never 1.
//  5. 3 SHR, then en=0 for 5 cycles with mode=CLEAR, then 5 SHR
//     -> pq and bit_cnt=3 frozen during en=0; word_valid pulses after the 5th SHR.
//  6. Shift 5 bits, then reset=0 for one edge; also mode=111 for 3 cycles after LOAD 8'h3C
//     -> pq=0, bit_cnt=0, no word_valid; pq stays 8'h3C.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, load, clear.
// Counts serial bits shifted in and pulses word_valid per full word.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       d,
  input  logic [WIDTH-1:0]           pdata,
  output logic                       q,
  output logic [WIDTH-1:0]           pq,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       word_valid
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] pq_q, pq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wv_q, wv_d;
  logic             left_q, left_d;

  always_comb begin
    pq_d   = pq_q;
    cnt_d  = cnt_q;
    wv_d   = 1'b0;
    left_d = left_q;
    if (en) begin
      case (mode)
        3'b001: begin
          pq_d   = {d, pq_q[WIDTH-1:1]};
          left_d = 1'b0;
        end
        3'b010: begin
          pq_d   = {pq_q[WIDTH-2:0], d};
          left_d = 1'b1;
        end
        3'b011: begin
          pq_d   = {pq_q[0], pq_q[WIDTH-1:1]};
          left_d = 1'b0;
        end
        3'b100: begin
          pq_d   = {pq_q[WIDTH-2:0], pq_q[WIDTH-1]};
          left_d = 1'b1;
        end
        3'b101: begin
          pq_d  = pdata;
          cnt_d = '0;
        end
        3'b110: begin
          pq_d  = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
      // Serial shifts advance the word tracker; wrap emits word_valid
      if (mode == 3'b001 || mode == 3'b010) begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          wv_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pq_q   <= RESET_VAL;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
      left_q <= 1'b0;
    end else begin
      pq_q   <= pq_d;
      cnt_q  <= cnt_d;
      wv_q   <= wv_d;
      left_q <= left_d;
    end
  end

  assign q          = left_q ? pq_q[WIDTH-1] : pq_q[0];
  assign pq         = pq_q;
  assign bit_cnt    = cnt_q;
  assign word_valid = wv_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8): arithmetic model
// checked every cycle plus hand-computed literal expectations.
module tb_universal_shift_reg;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic         d = 1'b0;
  logic [W-1:0] pdata = '0;
  logic         q;
  logic [W-1:0] pq;
  logic [3:0]   bit_cnt;
  logic         word_valid;

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode),
    .d(d), .pdata(pdata), .q(q), .pq(pq),
    .bit_cnt(bit_cnt), .word_valid(word_valid)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  logic [W-1:0] m_pq;
  int           m_cnt;
  logic         m_wv;
  logic         m_left;

  localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2,
    ROR = 3'd3, ROL = 3'd4, LOAD = 3'd5, CLR = 3'd6, RSV = 3'd7;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("model_pq", 32'(pq), 32'(m_pq));
      chk("model_cnt", 32'(bit_cnt), 32'(m_cnt));
      chk("model_wv", 32'(word_valid), 32'(m_wv));
      chk("model_q", 32'(q),
          32'(m_left ? m_pq[W-1] : m_pq[0]));
    end
  end

  task automatic bump();
    m_cnt = (m_cnt + 1) % W;
    if (m_cnt == 0) m_wv = 1'b1;
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic [2:0] m, input logic dd,
                     input logic [W-1:0] pd);
    reset = r; en = e; mode = m; d = dd; pdata = pd;
    @(posedge clock);
    if (!r) begin
      m_pq = '0; m_cnt = 0; m_wv = 1'b0; m_left = 1'b0;
    end else begin
      m_wv = 1'b0;
      if (e) begin
        case (m)
          SHR: begin
            m_pq = (m_pq >> 1) | (W'(dd) << (W-1));
            m_left = 1'b0; bump();
          end
          SHL: begin
            m_pq = (m_pq << 1) | W'(dd);
            m_left = 1'b1; bump();
          end
          ROR: begin
            m_pq = (m_pq >> 1) | (m_pq << (W-1));
            m_left = 1'b0;
          end
          ROL: begin
            m_pq = (m_pq << 1) | (m_pq >> (W-1));
            m_left = 1'b1;
          end
          LOAD: begin m_pq = pd; m_cnt = 0; end
          CLR:  begin m_pq = '0; m_cnt = 0; end
          default: ;
        endcase
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] dseq;
    logic [7:0] qexp;
    int pulses;

    @(negedge clock);
    // 1: reset dominates en/LOAD
    cyc(1'b0, 1'b1, LOAD, 1'b0, 8'hFF);
    chk_on = 1'b1;
    cyc(1'b0, 1'b1, LOAD, 1'b0, 8'hFF);
    chk("rst_pq", 32'(pq), 32'h00);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_cnt", 32'(bit_cnt), 32'h0);
    chk("rst_wv", 32'(word_valid), 32'h0);

    // 2: SHR 1,0,1,1,0,0,1,0
    dseq = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, SHR, dseq[i], 8'h00);
      chk("t2_wv", 32'(word_valid), 32'(i == 7));
    end
    chk("t2_pq", 32'(pq), 32'h4D);
    chk("t2_cnt", 32'(bit_cnt), 32'h0);

    // 3: LOAD A5, SHR with d=0, q before each shift
    cyc(1'b1, 1'b1, LOAD, 1'b0, 8'hA5);
    qexp = 8'b1010_0101;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_q", 32'(q), 32'(qexp[7-i]));
      cyc(1'b1, 1'b1, SHR, 1'b0, 8'h00);
      pulses += int'(word_valid);
    end
    chk("t3_pq", 32'(pq), 32'h00);
    chk("t3_pulses", 32'(pulses), 32'd1);

    // 4: rotates leave the counter alone
    cyc(1'b1, 1'b1, LOAD, 1'b0, 8'h81);
    cyc(1'b1, 1'b1, ROL, 1'b1, 8'h00);
    chk("t4_rol", 32'(pq), 32'h03);
    chk("t4_q_left", 32'(q), 32'h0);
    cyc(1'b1, 1'b1, ROR, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, ROR, 1'b1, 8'h00);
    chk("t4_ror", 32'(pq), 32'hC0);
    chk("t4_cnt", 32'(bit_cnt), 32'h0);
    chk("t4_wv", 32'(word_valid), 32'h0);

    // 5: en=0 freezes everything, mode ignored
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, SHR, 1'b1, 8'h00);
    chk("t5_pq3", 32'(pq), 32'hF8);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, CLR, 1'b0, 8'h00);
      chk("t5_frz_pq", 32'(pq), 32'hF8);
      chk("t5_frz_cnt", 32'(bit_cnt), 32'd3);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, SHR, 1'b0, 8'h00);
      chk("t5_wv", 32'(word_valid), 32'(i == 4));
    end
    chk("t5_pq", 32'(pq), 32'h07);

    // Direction change mid-word keeps the count; SHL q from msb
    cyc(1'b1, 1'b1, LOAD, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, SHR, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, SHL, 1'b0, 8'h00);
    chk("dir_cnt", 32'(bit_cnt), 32'd5);
    chk("dir_pq", 32'(pq), 32'h80);
    chk("dir_q", 32'(q), 32'h1);

    // Back-to-back words: one pulse every 8 cycles, no gap
    cyc(1'b1, 1'b1, CLR, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, SHL, i[0], 8'h00);
      chk("b2b_wv", 32'(word_valid), 32'(i == 7 || i == 15));
      pulses += int'(word_valid);
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_pq", 32'(pq), 32'h55);

    // 6: reset mid-word, then reserved mode holds
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, SHR, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, SHR, 1'b1, 8'h00);
    chk("t6_rst_pq", 32'(pq), 32'h00);
    chk("t6_rst_cnt", 32'(bit_cnt), 32'h0);
    chk("t6_rst_wv", 32'(word_valid), 32'h0);
    cyc(1'b1, 1'b1, LOAD, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, RSV, 1'b1, 8'hFF);
      chk("t6_rsv_pq", 32'(pq), 32'h3C);
      chk("t6_rsv_wv", 32'(word_valid), 32'h0);
    end
    cyc(1'b1, 1'b1, HOLD, 1'b1, 8'hFF);
    chk("hold_pq", 32'(pq), 32'h3C);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
